// File: rtl/dmem_pkg.sv
// Shared constants, address-region type and byte-lane merge helper for the
// data-memory responder.
package dmem_pkg;

   localparam logic [31:0] RAM_BASE_DEFAULT  = 32'h0000_0000;
   localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h4000_0000;
   localparam logic [31:0] MMIO_BYTES        = 32'd16;

   // Register offsets inside the MMIO window, word aligned.
   localparam logic [3:0] CNT_LO  = 4'h0;
   localparam logic [3:0] CNT_HI  = 4'h4;
   localparam logic [3:0] SCRATCH = 4'h8;
   localparam logic [3:0] TOHOST  = 4'hC;

   typedef enum logic [1:0] {
      REGION_RAM,
      REGION_MMIO,
      REGION_NONE
   } region_e;

   // Replace the lanes of old_word selected by mask with the matching lanes
   // of new_word.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
      logic [31:0] res;
      // NOTE: blocking '=' is correct here; this is combinational scratch,
      // not clocked state.
      res = old_word;
      for (int b = 0; b < 4; b++) begin
         if (mask[b]) res[8*b +: 8] = new_word[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enables and
// write-first read data.
module dmem_ram
   import dmem_pkg::*;
#(
   parameter int WORDS = 4096
) (
   input  logic                     clk,
   input  logic                     rd_en,
   input  logic [3:0]               wmask,
   input  logic [$clog2(WORDS)-1:0] addr,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata
);

   logic [31:0] mem [WORDS];
   logic [31:0] merged;

   // Write-first: a read that coincides with a write sees the new lanes.
   assign merged = byte_merge(mem[addr], wdata, wmask);

   // NOTE: neither the array nor rdata is reset; the parent masks rdata
   // until the first RAM load, and a memory reset would defeat RAM inference.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (wmask[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      if (rd_en) rdata <= merged;
   end

endmodule

// File: rtl/dmem.sv
// Data-port responder: RAM, MMIO window (cycle counter, scratch, tohost),
// out-of-range fault reporting and a sticky halt flag.
module dmem
   import dmem_pkg::*;
#(
   parameter int          RAM_WORDS = 4096,
   parameter logic [31:0] RAM_BASE  = RAM_BASE_DEFAULT,
   parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dmem_i_addr,
   input  logic        dmem_i_is_load,
   input  logic        dmem_i_is_store,
   input  logic [3:0]  dmem_i_wmask,
   input  logic [31:0] dmem_i_wdata,
   output logic [31:0] dmem_o_rdata,
   output logic        dmem_o_fault,
   output logic [31:0] dmem_o_tohost,
   output logic        dmem_o_halt
);

   localparam int          AW        = $clog2(RAM_WORDS);
   localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) << 2;

   logic [31:0] ram_off;
   logic [31:0] mmio_off;
   logic [3:0]  reg_off;
   logic [AW-1:0] word_idx;
   region_e     region;

   logic        load_ok;
   logic        store_ok;
   logic        fault_next;
   logic        ram_rd;
   logic [3:0]  ram_we;
   logic [31:0] ram_rdata;
   logic [31:0] mmio_rdata;
   logic [31:0] tohost_next;

   logic [63:0] cnt;
   logic [31:0] hi_shadow;
   logic [31:0] scratch_reg;
   logic [31:0] tohost_reg;
   logic        halt;
   logic        fault;
   logic        sel_ram;
   logic [31:0] aux_rdata;

   // Subtracting the base lets one unsigned compare cover both range ends.
   assign ram_off  = dmem_i_addr - RAM_BASE;
   assign mmio_off = dmem_i_addr - MMIO_BASE;
   assign word_idx = ram_off[AW+1:2];
   assign reg_off  = {mmio_off[3:2], 2'b00};

   always_comb begin
      region = REGION_NONE;
      if (ram_off < RAM_BYTES)        region = REGION_RAM;
      else if (mmio_off < MMIO_BYTES) region = REGION_MMIO;
   end

   assign load_ok    = dmem_i_is_load && !dmem_i_is_store;
   assign store_ok   = dmem_i_is_store && !dmem_i_is_load && !halt;
   assign fault_next = (dmem_i_is_load && dmem_i_is_store) ||
                       ((dmem_i_is_load || dmem_i_is_store) && region == REGION_NONE);

   assign ram_rd = !rst && load_ok && region == REGION_RAM;
   assign ram_we = (!rst && store_ok && region == REGION_RAM) ? dmem_i_wmask : 4'b0000;

   dmem_ram #(
      .WORDS (RAM_WORDS)
   ) u_ram (
      .clk   (clk),
      .rd_en (ram_rd),
      .wmask (ram_we),
      .addr  (word_idx),
      .wdata (dmem_i_wdata),
      .rdata (ram_rdata)
   );

   // NOTE: always_comb gets a default first so no path leaves it unassigned
   // and infers a latch.
   always_comb begin
      mmio_rdata = '0;
      if (region == REGION_MMIO) begin
         case (reg_off)
            CNT_LO:  mmio_rdata = cnt[31:0];
            CNT_HI:  mmio_rdata = hi_shadow;
            SCRATCH: mmio_rdata = scratch_reg;
            TOHOST:  mmio_rdata = tohost_reg;
            default: mmio_rdata = '0;
         endcase
      end
   end

   assign tohost_next = byte_merge(tohost_reg, dmem_i_wdata, dmem_i_wmask);

   // NOTE: clocked state uses non-blocking '<=' so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         hi_shadow   <= '0;
         scratch_reg <= '0;
         tohost_reg  <= '0;
         halt        <= 1'b0;
         fault       <= 1'b0;
         sel_ram     <= 1'b0;
         aux_rdata   <= '0;
      end else begin
         cnt   <= cnt + 64'd1;
         fault <= fault_next;

         // Read data sources only change on a load, so rdata holds otherwise.
         if (load_ok) begin
            sel_ram   <= (region == REGION_RAM);
            aux_rdata <= mmio_rdata;
            if (region == REGION_MMIO && reg_off == CNT_LO) hi_shadow <= cnt[63:32];
         end

         if (store_ok && region == REGION_MMIO) begin
            if (reg_off == SCRATCH) scratch_reg <= byte_merge(scratch_reg, dmem_i_wdata, dmem_i_wmask);
            if (reg_off == TOHOST) begin
               tohost_reg <= tohost_next;
               if (tohost_next != '0) halt <= 1'b1;
            end
         end
      end
   end

   assign dmem_o_rdata  = sel_ram ? ram_rdata : aux_rdata;
   assign dmem_o_fault  = fault;
   assign dmem_o_tohost = tohost_reg;
   assign dmem_o_halt   = halt;

endmodule

// File: tb/tb_dmem.sv
// Directed self-checking bench for dmem: RAM lanes, faults, counter wrap and
// shadow, scratch, tohost/halt and reset behaviour.
module tb_dmem;

   localparam logic [31:0] MMIO = 32'h4000_0000;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic        is_load;
   logic        is_store;
   logic [3:0]  wmask;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        fault;
   logic [31:0] tohost;
   logic        halt;

   int checks = 0;
   int errors = 0;

   dmem dut (
      .clk             (clk),
      .rst             (rst),
      .dmem_i_addr     (addr),
      .dmem_i_is_load  (is_load),
      .dmem_i_is_store (is_store),
      .dmem_i_wmask    (wmask),
      .dmem_i_wdata    (wdata),
      .dmem_o_rdata    (rdata),
      .dmem_o_fault    (fault),
      .dmem_o_tohost   (tohost),
      .dmem_o_halt     (halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one request at a falling edge and return at the next falling edge,
   // where that request's results are visible.
   task automatic cycle(input logic ld, input logic st, input logic [31:0] a,
                        input logic [3:0] m, input logic [31:0] d);
      is_load  = ld;
      is_store = st;
      addr     = a;
      wmask    = m;
      wdata    = d;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      is_load = 1'b0; is_store = 1'b0; addr = '0; wmask = '0; wdata = '0;
      @(negedge clk);
      @(negedge clk);
      check("reset_rdata",  rdata,  32'h0);
      check("reset_fault",  fault,  1'b0);
      check("reset_tohost", tohost, 32'h0);
      check("reset_halt",   halt,   1'b0);

      // Cycle 1 after release has cnt=0, so a load in cycle 5 returns 4.
      rst = 1'b0;
      repeat (4) cycle(0, 0, 32'h0, 4'h0, 32'h0);
      cycle(1, 0, MMIO + 32'h0, 4'h0, 32'h0);
      check("cnt_lo_after_reset", rdata, 32'd4);

      // RAM full-word store, read-after-write, byte lane merge, empty mask.
      cycle(0, 1, 32'h100, 4'b1111, 32'hDEAD_BEEF);
      check("store_no_fault", fault, 1'b0);
      cycle(1, 0, 32'h100, 4'h0, 32'h0);
      check("raw_full_word", rdata, 32'hDEAD_BEEF);
      check("raw_no_fault",  fault, 1'b0);
      cycle(0, 1, 32'h100, 4'b0010, 32'h0000_AB00);
      cycle(1, 0, 32'h100, 4'h0, 32'h0);
      check("lane1_merge", rdata, 32'hDEAD_ABEF);
      cycle(0, 1, 32'h100, 4'b0000, 32'hFFFF_FFFF);
      check("empty_mask_no_fault", fault, 1'b0);
      cycle(1, 0, 32'h100, 4'h0, 32'h0);
      check("empty_mask_noop", rdata, 32'hDEAD_ABEF);
      cycle(0, 0, 32'h0, 4'h0, 32'h0);
      check("rdata_holds", rdata, 32'hDEAD_ABEF);

      // Last RAM word; low address bits do not pick the word.
      cycle(0, 1, 32'h3FFC, 4'b1111, 32'h1234_5678);
      cycle(1, 0, 32'h3FFE, 4'h0, 32'h0);
      check("last_word", rdata, 32'h1234_5678);
      check("last_word_no_fault", fault, 1'b0);

      // One past RAM end faults for a single cycle and zeroes rdata.
      cycle(1, 0, 32'h4000, 4'h0, 32'h0);
      check("oor_load_rdata", rdata, 32'h0);
      check("oor_load_fault", fault, 1'b1);
      cycle(0, 0, 32'h0, 4'h0, 32'h0);
      check("fault_one_cycle", fault, 1'b0);

      // Load and store together: fault, no write, rdata unchanged.
      cycle(1, 0, 32'h100, 4'h0, 32'h0);
      cycle(1, 1, 32'h100, 4'b1111, 32'h1111_1111);
      check("both_fault", fault, 1'b1);
      check("both_rdata_held", rdata, 32'hDEAD_ABEF);
      cycle(1, 0, 32'h100, 4'h0, 32'h0);
      check("both_no_write", rdata, 32'hDEAD_ABEF);
      check("both_fault_cleared", fault, 1'b0);

      // Out-of-range store and the edge just past the MMIO window.
      cycle(0, 1, 32'h8000_0000, 4'b1111, 32'hFFFF_FFFF);
      check("oor_store_fault", fault, 1'b1);
      cycle(1, 0, MMIO + 32'h10, 4'h0, 32'h0);
      check("mmio_end_fault", fault, 1'b1);
      check("mmio_end_rdata", rdata, 32'h0);

      // Counter registers ignore stores silently.
      cycle(0, 1, MMIO + 32'h0, 4'b1111, 32'hFFFF_FFFF);
      check("cnt_store_no_fault", fault, 1'b0);

      // Scratch with byte masks.
      cycle(0, 1, MMIO + 32'h8, 4'b1111, 32'hA5A5_A5A5);
      cycle(0, 1, MMIO + 32'h8, 4'b0010, 32'h0000_3C00);
      cycle(1, 0, MMIO + 32'h8, 4'h0, 32'h0);
      check("scratch_masked", rdata, 32'hA5A5_3CA5);

      // Counter wrap; cnt_hi returns the shadow latched at the cnt_lo read.
      dut.cnt = 64'hFFFF_FFFF_FFFF_FFFE;
      cycle(0, 0, 32'h0, 4'h0, 32'h0);
      cycle(1, 0, MMIO + 32'h0, 4'h0, 32'h0);
      check("wrap_lo", rdata, 32'hFFFF_FFFF);
      cycle(1, 0, MMIO + 32'h4, 4'h0, 32'h0);
      check("wrap_hi_shadow", rdata, 32'hFFFF_FFFF);
      cycle(1, 0, MMIO + 32'h0, 4'h0, 32'h0);
      check("wrap_lo_after", rdata, 32'h1);
      cycle(1, 0, MMIO + 32'h4, 4'h0, 32'h0);
      check("wrap_hi_after", rdata, 32'h0);

      // Reset overrides a same-cycle store; RAM keeps its contents.
      rst = 1'b1;
      cycle(0, 1, 32'h100, 4'b1111, 32'h0);
      rst = 1'b0;
      cycle(1, 0, 32'h100, 4'h0, 32'h0);
      check("reset_blocks_store", rdata, 32'hDEAD_ABEF);
      cycle(1, 0, MMIO + 32'h8, 4'h0, 32'h0);
      check("scratch_reset", rdata, 32'h0);

      // tohost: zero result does not halt, nonzero halts.
      cycle(0, 1, MMIO + 32'hC, 4'b1111, 32'h0);
      check("tohost_zero_no_halt", halt, 1'b0);
      cycle(0, 1, MMIO + 32'hC, 4'b0001, 32'h0000_0001);
      check("halt_set",   halt,   1'b1);
      check("tohost_set", tohost, 32'h1);

      // After halt every store is dropped without fault; loads still work.
      cycle(0, 1, MMIO + 32'h8, 4'b1111, 32'h0000_0055);
      check("halted_store_no_fault", fault, 1'b0);
      cycle(0, 1, 32'h100, 4'b1111, 32'h0);
      cycle(0, 1, MMIO + 32'hC, 4'b1111, 32'h0);
      check("halted_tohost_kept", tohost, 32'h1);
      cycle(1, 0, MMIO + 32'h8, 4'h0, 32'h0);
      check("halted_scratch_dropped", rdata, 32'h0);
      cycle(1, 0, 32'h100, 4'h0, 32'h0);
      check("halted_ram_dropped", rdata, 32'hDEAD_ABEF);
      check("halt_sticky", halt, 1'b1);

      // One reset cycle clears halt, tohost and rdata.
      rst = 1'b1;
      cycle(0, 0, 32'h0, 4'h0, 32'h0);
      rst = 1'b0;
      check("rst_halt",   halt,   1'b0);
      check("rst_tohost", tohost, 32'h0);
      check("rst_rdata",  rdata,  32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
